// File: rtl/adder_tree_loader.sv
// adder_tree_loader
//
// Collects a stream of lane words into a group of LANES words and presents
// the group, zero-padded, to a downstream adder tree.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies in_data / in_last
//   in_ready   loader accepts a word this cycle
//   in_data    one lane word (ADDER_WIDTH bits)
//   in_last    marks the final word of a partial group
//   out_valid  a complete group is held on out_lanes
//   out_ready  adder tree consumes the group this cycle
//   out_lanes  group, lane k at [k*ADDER_WIDTH +: ADDER_WIDTH]
//   out_count  number of real lanes in the group (1..LANES)
module adder_tree_loader #(
  parameter int ADDER_WIDTH = 16,
  parameter int LANES       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDER_WIDTH-1:0]       in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*ADDER_WIDTH-1:0] out_lanes,
  output logic [$clog2(LANES):0]       out_count
);

  localparam int IW = $clog2(LANES);
  localparam int CW = IW + 1;

  localparam logic [IW-1:0] IDX_MAX = IW'(LANES - 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]                             state_q, state_d;
  logic [IW-1:0]                          idx_q, idx_d;
  logic [CW-1:0]                          count_q, count_d;
  logic [LANES-1:0][ADDER_WIDTH-1:0]      lanes_q, lanes_d;

  logic in_acc;
  logic out_xfer;

  // In HOLD the loader can only take a word when the held group leaves in the
  // same cycle, so in_ready follows out_ready there.
  assign in_ready  = (state_q == S_FILL) | out_ready;
  assign out_valid = (state_q == S_HOLD);
  assign out_lanes = lanes_q;
  assign out_count = count_q;

  assign in_acc   = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    lanes_d = lanes_q;

    case (state_q)
      S_FILL: begin
        if (in_acc) begin
          lanes_d[idx_q] = in_data;
          if (idx_q == IDX_MAX || in_last) begin
            // Unwritten upper lanes are already zero: they were cleared when
            // the previous group left (or by reset).
            state_d = S_HOLD;
            count_d = {1'b0, idx_q} + CW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      default: begin
        if (out_xfer) begin
          lanes_d = '0;
          count_d = '0;
          idx_d   = '0;
          state_d = S_FILL;
          if (in_acc) begin
            // The word arriving with the transfer opens the next group.
            lanes_d[0] = in_data;
            idx_d      = IW'(1);
            if (in_last) begin
              state_d = S_HOLD;
              count_d = CW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      count_q <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_loader.sv
module tb_adder_tree_loader;

  localparam int W  = 16;
  localparam int L  = 8;
  localparam int LW = L * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_lanes;
  logic [3:0]    out_count;

  typedef struct packed {
    logic [LW-1:0] lanes;
    logic [3:0]    cnt;
  } grp_t;

  grp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stalls = 0;
  bit streaming = 1'b0;

  adder_tree_loader #(.ADDER_WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lanes (out_lanes),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Group whose lane k holds base+k.
  function automatic logic [LW-1:0] seq_group(input logic [W-1:0] base);
    logic [LW-1:0] g;
    g = '0;
    for (int k = 0; k < L; k++) g[k*W +: W] = base + W'(k);
    return g;
  endfunction

  task automatic push_exp(input logic [LW-1:0] lanes, input logic [3:0] cnt);
    grp_t g;
    g.lanes = lanes;
    g.cnt   = cnt;
    exp_q.push_back(g);
  endtask

  // Offer one word; returns #1 after the edge that accepted it.
  task automatic send(input logic [W-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for word %h, expected 1", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitor: every group transfer is compared against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_group: got %h count %0d, expected none", out_lanes, out_count);
      end else begin
        grp_t e;
        e = exp_q.pop_front();
        check("group_lanes", out_lanes, e.lanes);
        check("group_count", LW'(out_count), LW'(e.cnt));
      end
    end
    if (streaming && in_valid && !in_ready) stalls++;
  end

  initial begin
    logic [LW-1:0] held;
    logic [31:0]   sum;
    int            c0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", LW'(out_valid), LW'(0));
    check("rst_out_lanes", out_lanes, '0);
    check("rst_out_count", LW'(out_count), LW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", LW'(in_ready), LW'(1));

    // Full group 1..8
    out_ready = 1'b1;
    push_exp(seq_group(16'd1), 4'd8);
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    check("full_latency_valid", LW'(out_valid), LW'(1));
    sum = 0;
    for (int k = 0; k < L; k++) sum += 32'(out_lanes[k*W +: W]);
    check("full_tree_sum", LW'(sum), LW'(36));
    repeat (2) @(posedge clk);
    #1;

    // Partial group closed by in_last
    push_exp({80'h0, 16'h0002, 16'h0001, 16'hFFFF}, 4'd3);
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Transfer and in_last word on the same edge
    out_ready = 1'b0;
    push_exp(seq_group(16'h0010), 4'd8);
    push_exp({112'h0, 16'h1234}, 4'd1);
    for (int i = 0; i < 8; i++) send(W'(16'h0010 + i), 1'b0);
    out_ready = 1'b1;
    send(16'h1234, 1'b1);
    check("simul_out_valid", LW'(out_valid), LW'(1));
    check("simul_lanes", out_lanes, {112'h0, 16'h1234});
    check("simul_count", LW'(out_count), LW'(1));
    repeat (2) @(posedge clk);
    #1;

    // Backpressure in HOLD with a word pending
    out_ready = 1'b0;
    push_exp(seq_group(16'h0020), 4'd8);
    push_exp(seq_group(16'h0030), 4'd8);
    for (int i = 0; i < 8; i++) send(W'(16'h0020 + i), 1'b0);
    held = seq_group(16'h0020);
    in_valid = 1'b1;
    in_data  = 16'h0030;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", LW'(in_ready), LW'(0));
      check("bp_lanes_stable", out_lanes, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", LW'(in_ready), LW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_pending_lane0", LW'(out_lanes[W-1:0]), LW'(16'h0030));
    for (int i = 1; i < 8; i++) send(W'(16'h0030 + i), 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Streaming: 32 words back to back
    for (int g = 0; g < 4; g++) push_exp(seq_group(W'(16'h0100 + 8 * g)), 4'd8);
    streaming = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 32; i++) send(W'(16'h0100 + i), 1'b0);
    check("stream_cycles", LW'(cyc - c0), LW'(32));
    streaming = 1'b0;
    check("stream_stalls", LW'(stalls), LW'(0));
    repeat (2) @(posedge clk);
    #1;

    // Reset while holding a group of 0x00AA words
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h00AA, 1'b0);
    check("hold_before_rst", LW'(out_valid), LW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", LW'(out_valid), LW'(0));
    check("rst_hold_lanes", out_lanes, '0);
    check("rst_hold_count", LW'(out_count), LW'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_exp({96'h0, 16'h0002, 16'h0001}, 4'd2);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    check("queue_drained", LW'(exp_q.size()), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/adder_tree_loader.md
ADDER_TREE_LOADER -- requirements
Module: adder_tree_loader

Interface
REQ-001 Parameter ADDER_WIDTH, default 16, SHALL set the width of one lane word.
REQ-002 Parameter LANES, default 8, SHALL set the lanes per group; legal range 2..16, power of two.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 in_valid  input  1  SHALL qualify in_data and in_last.
REQ-006 in_ready  output  1  SHALL indicate that the loader accepts a word this cycle.
REQ-007 in_data  input  ADDER_WIDTH  SHALL carry one lane word.
REQ-008 in_last  input  1  SHALL mark the final word of a partial group.
REQ-009 out_valid  output  1  SHALL indicate that a complete group is held on out_lanes.
REQ-010 out_ready  input  1  SHALL indicate that the adder tree consumes the group this cycle.
REQ-011 out_lanes  output  LANES*ADDER_WIDTH  SHALL carry the group; lane k occupies bits [k*ADDER_WIDTH +: ADDER_WIDTH].
REQ-012 out_count  output  $clog2(LANES)+1  SHALL give the number of real lanes in the group (1..LANES).

Function
REQ-013 A word SHALL transfer on a cycle with in_valid=1 and in_ready=1; a group SHALL transfer on a cycle with out_valid=1 and out_ready=1.
REQ-014 The loader SHALL have two states, FILL and HOLD; the reset state SHALL be FILL.
REQ-015 In FILL, in_ready SHALL be 1, out_valid 0; each accepted word SHALL be written to lane idx, then idx SHALL increment.
REQ-016 FILL->HOLD SHALL occur on acceptance of the word at idx=LANES-1 or of any word with in_last=1; out_valid SHALL be 1 on the next cycle (latency one cycle from last word).
REQ-017 On in_last closing a group early, lanes idx+1..LANES-1 SHALL read zero, and out_count SHALL equal idx+1.
REQ-018 A full group SHALL report out_count=LANES regardless of in_last on the final word.
REQ-019 In HOLD, out_lanes and out_count SHALL remain stable until the group transfers; out_valid SHALL not drop without a transfer.
REQ-020 In HOLD, in_ready SHALL equal out_ready (combinational pass-through; no other combinational input-to-output paths).
REQ-021 In HOLD with group transfer and no word accepted: next state FILL, idx=0, all lanes cleared to zero.
REQ-022 In HOLD with group transfer and simultaneous word accept: the word SHALL become lane 0 of the new group, idx=1, other lanes cleared; if that word has in_last=1 (or LANES=1 impossible), state SHALL stay HOLD with out_count=1.
REQ-023 Sustained in_valid=1, out_ready=1 SHALL give one word per cycle with no bubbles.
REQ-024 in_data/in_last SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.
REQ-025 The lane index counter SHALL never exceed LANES-1; idx SHALL wrap to 0 only through a group transfer.

Reset
REQ-026 rst_n=0 SHALL immediately force: state FILL, idx=0, out_valid=0, out_lanes=0, out_count=0; in_ready SHALL be 1 once rst_n=1.
REQ-027 Reset mid-group or in HOLD SHALL discard the partial or held group with no output transfer.
REQ-028 Reset deassertion SHALL be synchronised externally; no word SHALL be accepted on the cycle rst_n rises.

Verification
REQ-029 Full group: words 1..8 on consecutive cycles, out_ready=1 -> out_valid one cycle after word 8, lanes 1..8, out_count=8; adder tree sum = 36.
REQ-030 Partial group: words 0xFFFF,0x0001,0x0002 with in_last on third -> lanes {0xFFFF,1,2,0,0,0,0,0}, out_count=3.
REQ-031 Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_lanes stable, no words lost; release -> next group begins with the pending word as lane 0.
REQ-032 Streaming: 32 words continuous, out_ready=1 -> four groups, no bubbles, in_ready never low.
REQ-033 Reset in HOLD: rst_n low after group of 0x00AA words held -> out_valid=0 and out_lanes=0 immediately; post-reset first group contains only new words.
REQ-034 Simultaneous edge: HOLD, out_ready=1, in_valid=1, in_last=1, in_data=0x1234 -> stays HOLD, out_lanes lane0=0x1234, others 0, out_count=1.
